zuc_ks_xor: RTL
===============

ZUC_KS_XOR -- requirements
Module: zuc_ks_xor

Interface
REQ-001 SHALL have parameter lw, default 16, the bit width of the message-length field in bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset: synchronous and active-high.
REQ-004 SHALL have port s_cmd_valid / s_cmd_ready / s_cmd_len, input / output / input [lw-1:0], the message command carrying the length in bits.
REQ-005 SHALL have port s_ks_valid / s_ks_ready / s_ks_data, input / output / input [31:0], keystream words from the upstream keystream register slice.
REQ-006 SHALL have port s_msg_valid / s_msg_ready / s_msg_data, input / output / input [31:0], plaintext or ciphertext words, MSB first.
REQ-007 SHALL have port m_valid / m_ready / m_data / m_last, output / input / output [31:0] / output, the result word stream.
REQ-008 SHALL have port ks_flush, output, 1 bit, a one-cycle pulse that drives the flush input of the upstream keystream slice.
REQ-009 SHALL have port busy, output, 1 bit, high while in RUN or while m_valid is high.

Function
REQ-010 SHALL have two states: IDLE and RUN.
REQ-011 IDLE: s_cmd_ready SHALL be 1; s_ks_ready and s_msg_ready SHALL be 0.
REQ-012 Command accept in IDLE with len != 0 SHALL load words_left = ceil(len/32) (lw-4 bits) and tail = len mod 32, then go to RUN.
REQ-013 Command accept with len == 0 SHALL stay in IDLE, produce no output word, and pulse ks_flush in the next cycle.
REQ-014 RUN: s_cmd_ready SHALL be 0; define can_out = !m_valid || m_ready.
REQ-015 RUN: s_ks_ready SHALL be s_msg_valid && can_out, and s_msg_ready SHALL be s_ks_valid && can_out, so ks and msg words are consumed only together (joint fire).
REQ-016 Joint fire SHALL register m_data = s_ks_data ^ s_msg_data and set m_valid = 1 on the next cycle, giving 1-cycle latency.
REQ-017 With m_ready held high, throughput SHALL be 1 word per cycle.
REQ-018 On the joint fire where words_left == 1: m_last SHALL be 1, and if tail != 0 only the top tail bits of m_data SHALL be kept, with the lower 32-tail bits forced to 0.
REQ-019 On that final fire, state SHALL return to IDLE and ks_flush SHALL pulse high for exactly one cycle, in the following cycle.
REQ-020 m_valid SHALL clear on m_ready when no joint fire occurs in the same cycle; a simultaneous m_ready and joint fire SHALL reload the output register.
REQ-021 m_data and m_last SHALL remain stable while m_valid && !m_ready.
REQ-022 A new command SHALL be accepted in IDLE while the last word of the previous message still waits in the output register; word order SHALL be preserved.
REQ-023 An input word presented on only one of ks or msg SHALL NOT be consumed.
REQ-024 s_cmd_len SHALL be sampled only on command fire; later changes SHALL be ignored.

Reset
REQ-025 rst SHALL set state = IDLE, m_valid = 0, m_data = 0, m_last = 0, ks_flush = 0, busy = 0, words_left = 0 and tail = 0, taking effect at the next clock edge.
REQ-026 rst mid-message SHALL abandon the message with no further outputs and no ks_flush pulse; s_cmd_ready SHALL be 1 on the cycle after rst deasserts.
REQ-027 rst SHALL override all simultaneous handshakes.

Verification
REQ-028 len=64; ks 0xFFFF0000, 0x12345678; msg 0x0F0F0F0F, 0x11111111; m_ready=1 -> 0xF0F00F0F (last=0), then 0x03254769 (last=1); one ks_flush pulse.
REQ-029 len=40; ks 0x00000000, 0x5A000000; msg 0xDEADBEEF, 0xFFFFFFFF -> 0xDEADBEEF (last=0), then 0xA5000000 (last=1).
REQ-030 len=0 -> no m_valid ever; ks_flush high for one cycle; busy stays 0; s_cmd_ready stays 1.
REQ-031 len=96 with m_ready low for 5 cycles after the first word -> m_data is held stable, at most one word is pending in the output register, and all 3 words arrive in order.
REQ-032 s_ks_valid=1 with s_msg_valid=0 for 10 cycles in RUN -> s_ks_ready=0 and m_valid=0 throughout.
REQ-033 rst pulsed after 1 of 3 words of a message -> m_valid=0 and s_cmd_ready=1 in the next cycle; no ks_flush pulse; a following len=32 message completes correctly.

Source files
------------

// File: rtl/zuc_ks_xor.sv
// zuc_ks_xor: XORs keystream words with message words, masking the tail of the final word
module zuc_ks_xor #(
  parameter int lw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_cmd_valid,
  output logic          s_cmd_ready,
  input  logic [lw-1:0] s_cmd_len,
  input  logic          s_ks_valid,
  output logic          s_ks_ready,
  input  logic [31:0]   s_ks_data,
  input  logic          s_msg_valid,
  output logic          s_msg_ready,
  input  logic [31:0]   s_msg_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic          m_last,
  output logic          ks_flush,
  output logic          busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [lw-5:0] words_left_q, words_left_d;
  logic [4:0] tail_q, tail_d;
  logic [31:0] m_data_q, m_data_d, mask;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, ks_flush_q, ks_flush_d;
  logic run, can_out, fire, cmd_fire, last;
  assign run = state_q == RUN;
  assign can_out = !m_valid_q || m_ready;
  assign fire = run && s_ks_valid && s_msg_valid && can_out;
  assign cmd_fire = !run && s_cmd_valid;
  assign last = words_left_q == (lw-4)'(1);
  assign mask = tail_q == 5'd0 ? '1 : ~(32'hFFFF_FFFF >> tail_q);
  assign s_cmd_ready = !run;
  assign s_ks_ready = run && s_msg_valid && can_out;
  assign s_msg_ready = run && s_ks_valid && can_out;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign m_last = m_last_q;
  assign ks_flush = ks_flush_q;
  assign busy = run || m_valid_q;
  // command load, joint ks/msg fire into the output register, and output drain
  always_comb begin
    state_d = state_q;
    words_left_d = words_left_q;
    tail_d = tail_q;
    m_valid_d = m_valid_q && !m_ready;
    m_data_d = m_data_q;
    m_last_d = m_last_q;
    ks_flush_d = cmd_fire && s_cmd_len == '0;
    if (cmd_fire && s_cmd_len != '0) begin
      state_d = RUN;
      words_left_d = {1'b0, s_cmd_len[lw-1:5]} + (lw-4)'(|s_cmd_len[4:0]);
      tail_d = s_cmd_len[4:0];
    end
    if (fire) begin
      m_valid_d = 1'b1;
      m_data_d = (s_ks_data ^ s_msg_data) & (last ? mask : '1);
      m_last_d = last;
      words_left_d = words_left_q - (lw-4)'(1);
      state_d = last ? IDLE : RUN;
      ks_flush_d = last;
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      words_left_q <= '0;
      tail_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
      ks_flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      words_left_q <= words_left_d;
      tail_q <= tail_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
      ks_flush_q <= ks_flush_d;
    end
  end
endmodule
